// File: rtl/brightness_tile_sequencer.sv
// brightness_tile_sequencer
//   Drives the NxN systolic TPU for the brightness filter one tile at a time.
//   Each tile goes through four phases. First it reads N*N pixels from the pixel
//   RAM. Next it feeds them to the array with a diagonal skew. It then lets the
//   pipeline drain, and finally writes the N normalized row results to the
//   result RAM.
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             one-cycle job request, honoured only in IDLE
//   i_base_addr         pixel RAM address of tile 0 (latched at start)
//   i_num_tiles         tiles per job, clamped to 4 (latched at start)
//   i_gain              brightness weight (latched at start)
//   o_busy / o_done     job in progress / one-cycle completion pulse
//   o_ram_addr/o_ram_rden, i_ram_q   pixel RAM read port (1-cycle read latency)
//   o_data_arr, o_wt_arr, o_tpu_valid  TPU lanes, weights and feed strobe
//   i_norm_in           TPU row-3 normalized outputs
//   o_res_wr, o_res_addr, o_res_data   result RAM write port
module brightness_tile_sequencer #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int WW    = 16,
    parameter int NW    = 16,
    parameter int AW    = 6,
    parameter int DRAIN = 7
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [AW-1:0]   i_base_addr,
    input  logic [2:0]      i_num_tiles,
    input  logic [WW-1:0]   i_gain,
    output logic            o_busy,
    output logic            o_done,
    output logic [AW-1:0]   o_ram_addr,
    output logic            o_ram_rden,
    input  logic [DW-1:0]   i_ram_q,
    output logic [N*DW-1:0] o_data_arr,
    output logic [N*WW-1:0] o_wt_arr,
    output logic            o_tpu_valid,
    input  logic [N*NW-1:0] i_norm_in,
    output logic            o_res_wr,
    output logic [AW-1:0]   o_res_addr,
    output logic [N*NW-1:0] o_res_data
);

    localparam int NPIX  = N * N;
    localparam int NFEED = 2 * N - 1;
    localparam int CW    = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FEED, S_DRAIN, S_STORE, S_NEXT, S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_tile, w_tile_nxt, r_ntiles, w_ntiles_clamp;
    logic [AW-1:0]   r_base, w_base_eff;
    logic [WW-1:0]   r_gain, w_gain_eff;
    logic [NPIX*DW-1:0] r_buf;

    logic            r_busy, r_done, r_rden, r_valid, r_wr;
    logic [AW-1:0]   r_addr, r_res_addr;
    logic [N*DW-1:0] r_data;
    logic [N*WW-1:0] r_wt;
    logic [N*NW-1:0] r_res_data;

    logic            w_busy_nxt, w_done_nxt, w_rden_nxt, w_valid_nxt, w_wr_nxt;
    logic [AW-1:0]   w_addr_nxt, w_res_addr_nxt;
    logic [N*DW-1:0] w_data_nxt;
    logic [N*WW-1:0] w_wt_nxt;
    logic [N*NW-1:0] w_res_data_nxt;

    assign w_ntiles_clamp = (i_num_tiles > 3'd4) ? 3'd4 : i_num_tiles;

    // Outputs are registered from next-state values, so the first FETCH cycle
    // has to see the job parameters that are being latched in the same edge.
    assign w_base_eff = (r_state == S_IDLE) ? i_base_addr : r_base;
    assign w_gain_eff = (r_state == S_IDLE) ? i_gain      : r_gain;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tile_nxt  = r_tile;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_tile_nxt = '0;
                if (i_start)
                    w_state_nxt = (w_ntiles_clamp == 3'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (r_cnt == CW'(NPIX)) begin
                    w_state_nxt = S_FEED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_FEED: begin
                if (r_cnt == CW'(NFEED - 1)) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == CW'(DRAIN - 1)) begin
                    w_state_nxt = S_STORE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STORE: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_state_nxt = S_NEXT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_NEXT: begin
                w_tile_nxt  = r_tile + 3'd1;
                w_cnt_nxt   = '0;
                w_state_nxt = ((r_tile + 3'd1) == r_ntiles) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_tile_nxt  = '0;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tile_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        int d;
        d              = 0;
        w_busy_nxt     = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_done_nxt     = (w_state_nxt == S_DONE);
        w_rden_nxt     = (w_state_nxt == S_FETCH) && (w_cnt_nxt < CW'(NPIX));
        w_addr_nxt     = '0;
        if (w_rden_nxt)
            w_addr_nxt = w_base_eff + AW'(w_tile_nxt * NPIX) + AW'(w_cnt_nxt);
        w_valid_nxt    = (w_state_nxt == S_FEED);
        w_data_nxt     = '0;
        // Diagonal skew: lane c at step s carries row (s-c), column c.
        if (w_valid_nxt) begin
            for (int unsigned c = 0; c < N; c++) begin
                d = int'(w_cnt_nxt) - int'(c);
                if (d >= 0 && d < N)
                    w_data_nxt[c*DW +: DW] = r_buf[(d*N + int'(c))*DW +: DW];
            end
        end
        w_wt_nxt       = w_busy_nxt ? {N{w_gain_eff}} : '0;
        w_wr_nxt       = (w_state_nxt == S_STORE);
        w_res_addr_nxt = w_wr_nxt ? AW'(w_tile_nxt * N + w_cnt_nxt) : '0;
        w_res_data_nxt = w_wr_nxt ? i_norm_in : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tile     <= '0;
            r_ntiles   <= '0;
            r_base     <= '0;
            r_gain     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rden     <= 1'b0;
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_wt       <= '0;
            r_wr       <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tile     <= w_tile_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_base   <= i_base_addr;
                r_gain   <= i_gain;
                r_ntiles <= w_ntiles_clamp;
            end
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_rden     <= w_rden_nxt;
            r_addr     <= w_addr_nxt;
            r_valid    <= w_valid_nxt;
            r_data     <= w_data_nxt;
            r_wt       <= w_wt_nxt;
            r_wr       <= w_wr_nxt;
            r_res_addr <= w_res_addr_nxt;
            r_res_data <= w_res_data_nxt;
        end
    end

    // Read data trails its address by one cycle: FETCH cycle k+1 holds pixel k.
    always_ff @(posedge i_clk) begin
        if (r_state == S_FETCH && r_cnt != '0)
            r_buf[(int'(r_cnt) - 1)*DW +: DW] <= i_ram_q;
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_ram_rden  = r_rden;
    assign o_ram_addr  = r_addr;
    assign o_tpu_valid = r_valid;
    assign o_data_arr  = r_data;
    assign o_wt_arr    = r_wt;
    assign o_res_wr    = r_wr;
    assign o_res_addr  = r_res_addr;
    assign o_res_data  = r_res_data;

endmodule

// File: tb/tb_brightness_tile_sequencer.sv
// Directed bench for brightness_tile_sequencer: a table of jobs with hand-derived
// completion cycles and transaction counts, checked cycle by cycle against the
// fixed 36-cycle-per-tile schedule, plus reset and start-overlap sequences.
module tb_brightness_tile_sequencer;

    localparam int N = 4, DW = 8, WW = 16, NW = 16, AW = 6;

    logic            clk = 1'b0;
    logic            reset, start;
    logic [AW-1:0]   base_addr;
    logic [2:0]      num_tiles;
    logic [WW-1:0]   gain;
    logic            busy, done, ram_rden, tpu_valid, res_wr;
    logic [AW-1:0]   ram_addr, res_addr;
    logic [DW-1:0]   ram_q;
    logic [N*DW-1:0] data_arr;
    logic [N*WW-1:0] wt_arr;
    logic [N*NW-1:0] norm_in, res_data;

    logic [DW-1:0]   mem [64];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rden) ram_q <= mem[ram_addr];

    brightness_tile_sequencer #(.N(N), .DW(DW), .WW(WW), .NW(NW), .AW(AW), .DRAIN(7)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr),
        .i_num_tiles(num_tiles), .i_gain(gain), .o_busy(busy), .o_done(done),
        .o_ram_addr(ram_addr), .o_ram_rden(ram_rden), .i_ram_q(ram_q),
        .o_data_arr(data_arr), .o_wt_arr(wt_arr), .o_tpu_valid(tpu_valid),
        .i_norm_in(norm_in), .o_res_wr(res_wr), .o_res_addr(res_addr),
        .o_res_data(res_data)
    );

    typedef struct {
        logic [5:0]  base;
        logic [2:0]  nt;
        logic [15:0] gain;
        int tiles;        // effective (clamped) tile count
        int exp_done;     // cycle of done, start sampled at cycle 0
        int exp_reads;
        int exp_wr;
        int exp_valid;
        int restart_rel;  // cycle at which start is pulsed again (0 = never)
        int alter_rel;    // cycle at which base/gain/num_tiles are disturbed (0 = never)
    } vec_t;

    vec_t vecs[7];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int rel, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, rel, act, exp);
        end
    endtask

    task automatic chk_all_zero(input int rel);
        chk("rst_busy", rel, busy, 0);
        chk("rst_done", rel, done, 0);
        chk("rst_rden", rel, ram_rden, 0);
        chk("rst_ram_addr", rel, ram_addr, 0);
        chk("rst_data_arr", rel, data_arr, 0);
        chk("rst_wt_arr", rel, wt_arr, 0);
        chk("rst_tpu_valid", rel, tpu_valid, 0);
        chk("rst_res_wr", rel, res_wr, 0);
        chk("rst_res_addr", rel, res_addr, 0);
        chk("rst_res_data", rel, res_data, 0);
    endtask

    // Entered and left just after a falling edge with the DUT idle.
    task automatic run_job(input vec_t v);
        int nrd, nwr, nval, ndone, p, t, d, a;
        bit inj, e_rden, e_val, e_wr;
        logic [31:0] exp_data;
        nrd = 0; nwr = 0; nval = 0; ndone = 0;
        base_addr = v.base; num_tiles = v.nt; gain = v.gain; start = 1'b1;
        @(posedge clk);
        for (int r = 1; r <= v.exp_done + 1; r++) begin
            @(negedge clk);
            inj    = (r <= 36 * v.tiles);
            p      = (r - 1) % 36;
            t      = (r - 1) / 36;
            e_rden = inj && (p < 16);
            e_val  = inj && (p >= 17) && (p <= 23);
            e_wr   = inj && (p >= 31) && (p <= 34);
            chk("busy", r, busy, inj);
            chk("done", r, done, r == v.exp_done);
            chk("ram_rden", r, ram_rden, e_rden);
            chk("tpu_valid", r, tpu_valid, e_val);
            chk("res_wr", r, res_wr, e_wr);
            chk("wt_arr", r, wt_arr, inj ? {4{v.gain}} : 64'h0);
            if (ram_rden) nrd++;
            if (tpu_valid) nval++;
            if (res_wr) nwr++;
            if (done) ndone++;
            if (ram_rden && e_rden) begin
                a = (int'(v.base) + t*16 + p) % 64;
                chk("ram_addr", r, ram_addr, a);
            end
            exp_data = '0;
            if (e_val) begin
                for (int c = 0; c < N; c++) begin
                    d = (p - 17) - c;
                    if (d >= 0 && d < N)
                        exp_data[c*DW +: DW] = mem[(int'(v.base) + t*16 + d*4 + c) % 64];
                end
            end
            chk("data_arr", r, data_arr, exp_data);
            if (v.base == 6'd0 && v.tiles >= 1 && r == 18)
                chk("feed_step0", r, data_arr, 32'h0000_0001);
            if (v.base == 6'd0 && v.tiles >= 1 && r == 21)
                chk("feed_step3", r, data_arr, 32'h0407_0A0D);
            if (res_wr && e_wr) begin
                chk("res_addr", r, res_addr, (t*4 + p - 31) % 64);
                chk("res_data", r, res_data, norm_in);
            end
            start = (r == v.restart_rel);
            if (r == v.alter_rel) begin
                gain = ~v.gain; base_addr = ~v.base; num_tiles = 3'd1;
            end
            norm_in = {$urandom, $urandom};
        end
        chk("n_reads", v.exp_done, nrd, v.exp_reads);
        chk("n_valid", v.exp_done, nval, v.exp_valid);
        chk("n_res_wr", v.exp_done, nwr, v.exp_wr);
        chk("n_done", v.exp_done, ndone, 1);
    endtask

    initial begin
        //          base   nt    gain      T  done rd  wr val restart alter
        vecs[0] = '{6'd0,  3'd1, 16'h0100, 1, 37,  16, 4,  7,  20,  0};
        vecs[1] = '{6'd0,  3'd4, 16'h1234, 4, 145, 64, 16, 28, 0,   50};
        vecs[2] = '{6'd0,  3'd0, 16'h00FF, 0, 1,   0,  0,  0,  0,   0};
        vecs[3] = '{6'd9,  3'd6, 16'hBEEF, 4, 145, 64, 16, 28, 0,   0};
        vecs[4] = '{6'd56, 3'd1, 16'h0001, 1, 37,  16, 4,  7,  37,  0};
        vecs[5] = '{6'd33, 3'd2, 16'hFFFF, 2, 73,  32, 8,  14, 0,   10};
        vecs[6] = '{6'd63, 3'd7, 16'hA5C3, 4, 145, 64, 16, 28, 0,   0};

        for (int k = 0; k < 64; k++) mem[k] = 8'(k + 1);
        reset = 1'b1; start = 1'b0; base_addr = '0; num_tiles = '0; gain = '0; norm_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero(0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Reset in the middle of tile 0's DRAIN phase aborts the job.
        base_addr = 6'd0; num_tiles = 3'd2; gain = 16'h55AA; start = 1'b1;
        @(posedge clk);
        for (int r = 1; r <= 27; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_busy", 27, busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero(28);
        reset = 1'b0;
        for (int r = 29; r < 90; r++) begin
            @(negedge clk);
            chk("abort_done", r, done, 0);
            chk("abort_res_wr", r, res_wr, 0);
            chk("abort_busy", r, busy, 0);
            chk("abort_tpu_valid", r, tpu_valid, 0);
        end

        run_job(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
